sync_fifo_stream_drainer: RTL and testbench

- Downstream neighbour of the synchronous circular FIFO: pops the FIFO through its rd_en/empty/data interface and re-presents words as a valid/ready stream.
- Absorbs the FIFO's 1-cycle read latency with a 3-entry skid buffer, so a continuously ready consumer gets 1 word/cycle.
- Provides a flush mode that drains and discards the FIFO contents.
- Keeps a count of delivered words.

---
 rtl/sync_fifo_pkg.sv | 18 +
 rtl/sync_fifo_stream_drainer_skid.sv | 69 ++++++
 rtl/sync_fifo_stream_drainer.sv | 112 +++++++++++
 tb/tb_sync_fifo_stream_drainer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the synchronous FIFO neighbourhood.
//   SKID_DEPTH    : entries in the drainer's skid buffer
//   drain_state_t : drainer FSM states
//   next_idx()    : advance an index into a SKID_DEPTH-entry ring (0,1,2,0,...)
package sync_fifo_pkg;

  localparam int unsigned SKID_DEPTH = 3;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } drain_state_t;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'(SKID_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/sync_fifo_stream_drainer_skid.sv
// skid_buffer3: three-entry register ring with push/pop and occupancy.
// Reusable in front of any valid/ready stream sink.
//   clk_i, rst_i   : clock and synchronous active-high reset (clears storage too)
//   clear_i        : drop all buffered words; takes priority over push/pop
//   push_i         : write push_data_i at the tail
//   pop_i          : consumer accepts the head word (ignored when empty)
//   occ_o          : occupancy 0..3
//   valid_o        : buffer holds at least one word
//   head_data_o    : oldest buffered word
module skid_buffer3
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            occ_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  localparam logic [1:0] OccFull = 2'(SKID_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [1:0]            head_q, tail_q, occ_q;
  logic                  do_push, do_pop;

  assign do_pop  = pop_i && (occ_q != 2'd0);
  // The upstream credit rule keeps us from overflowing; the guard only
  // protects stored words if a caller ever breaks that rule.
  assign do_push = push_i && ((occ_q != OccFull) || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      occ_q  <= 2'd0;
      for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear_i) begin
      head_q <= 2'd0;
      tail_q <= 2'd0;
      occ_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= next_idx(tail_q);
      end
      if (do_pop) begin
        head_q <= next_idx(head_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occ_o       = occ_q;
  assign valid_o     = (occ_q != 2'd0);
  assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/sync_fifo_stream_drainer.sv
// Pops a synchronous FIFO (1-cycle read latency) and re-presents its words as
// a valid/ready stream, with a drain-and-discard flush mode and a count of
// delivered words.
//   clk_i, rst_i      : clock and synchronous active-high reset
//   fifo_empty_i      : FIFO empty flag
//   fifo_data_i       : FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_rd_en_o      : FIFO pop request
//   m_data_o/m_valid_o/m_ready_i : output stream
//   flush_i           : single-cycle drain-and-discard request (ignored in FLUSH)
//   flush_busy_o      : high while flushing
//   flush_done_o      : one-cycle pulse after returning to RUN
//   words_drained_o   : stream handshakes, wrapping
module sync_fifo_stream_drainer
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  input  logic                  flush_i,
  output logic                  flush_busy_o,
  output logic                  flush_done_o,
  output logic [CNT_WIDTH-1:0]  words_drained_o
);

  drain_state_t         state_q, state_d;
  logic                 inflight_q;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic       clear, push, handshake;
  logic [1:0] occ;
  logic [2:0] credit_used;

  // Words already buffered plus the one arriving this cycle; a new pop is only
  // issued when its data is guaranteed a slot, independent of m_ready_i.
  assign credit_used = {1'b0, occ} + {2'b00, inflight_q};

  always_comb begin
    state_d      = state_q;
    fifo_rd_en_o = 1'b0;
    clear        = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      RUN: begin
        fifo_rd_en_o = !fifo_empty_i && (credit_used < 3'(SKID_DEPTH));
        if (flush_i) begin
          state_d = FLUSH;
          clear   = 1'b1;
        end
      end
      FLUSH: begin
        fifo_rd_en_o = !fifo_empty_i;
        // Leave only once nothing is left in the FIFO or on its read port.
        if (fifo_empty_i && !inflight_q) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    if (rst_i) begin
      fifo_rd_en_o = 1'b0;
    end
  end

  // Returned words are only kept in RUN; in FLUSH they fall on the floor.
  assign push      = inflight_q && (state_q == RUN);
  assign handshake = m_valid_o && m_ready_i;

  skid_buffer3 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear),
    .push_i     (push),
    .push_data_i(fifo_data_i),
    .pop_i      (m_ready_i),
    .occ_o      (occ),
    .valid_o    (m_valid_o),
    .head_data_o(m_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en_o;
      done_q     <= done_d;
      if (handshake) begin
        cnt_q <= cnt_q + {{(CNT_WIDTH - 1){1'b0}}, 1'b1};
      end
    end
  end

  assign flush_busy_o    = (state_q == FLUSH);
  assign flush_done_o    = done_q;
  assign words_drained_o = cnt_q;

endmodule

// File: tb/tb_sync_fifo_stream_drainer.sv
module tb_sync_fifo_stream_drainer;

  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, fifo_empty, rd_en, m_valid, m_ready, flush, busy, done;
  logic [DW-1:0] m_data;
  logic [DW-1:0] fifo_data = '0;
  logic [31:0]   words;

  logic          fifo_empty4, rd_en4, m_valid4, m_ready4, busy4, done4;
  logic          flush4 = 1'b0;
  logic [DW-1:0] fifo_data4, m_data4;
  logic [3:0]    words4;

  int tests = 0;
  int fails = 0;

  // FIFO model: 1-cycle read latency, written by the stimulus at negedges.
  logic [DW-1:0] fifo_mem [4096];
  int pushes = 0;
  int pops   = 0;
  assign fifo_empty = (pushes == pops);

  always @(posedge clk) begin
    if (rd_en && (pushes != pops)) begin
      fifo_data <= fifo_mem[pops % 4096];
      pops      <= pops + 1;
    end
  end

  sync_fifo_stream_drainer #(.DATA_WIDTH(DW), .CNT_WIDTH(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .fifo_empty_i   (fifo_empty),
    .fifo_data_i    (fifo_data),
    .fifo_rd_en_o   (rd_en),
    .m_data_o       (m_data),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .flush_i        (flush),
    .flush_busy_o   (busy),
    .flush_done_o   (done),
    .words_drained_o(words)
  );

  sync_fifo_stream_drainer #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut4 (
    .clk_i          (clk),
    .rst_i          (rst),
    .fifo_empty_i   (fifo_empty4),
    .fifo_data_i    (fifo_data4),
    .fifo_rd_en_o   (rd_en4),
    .m_data_o       (m_data4),
    .m_valid_o      (m_valid4),
    .m_ready_i      (m_ready4),
    .flush_i        (flush4),
    .flush_busy_o   (busy4),
    .flush_done_o   (done4),
    .words_drained_o(words4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_write(input logic [DW-1:0] w);
    fifo_mem[pushes % 4096] = w;
    pushes = pushes + 1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nrd, ndone, wr, rx, base_push, base_pop, hs;
    logic          prev_stall;
    logic [DW-1:0] prev_data;

    rst = 1'b1; m_ready = 1'b0; flush = 1'b0;
    fifo_empty4 = 1'b1; m_ready4 = 1'b0; fifo_data4 = 64'h5A;
    for (int k = 0; k < 8; k++) fifo_write(64'h10 + 64'(k));
    step(); step();

    // Reset state, with FIFO already non-empty
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_words", words, 0);

    // T1: streaming with ready held high
    m_ready = 1'b1; rst = 1'b0; #1;
    n = 0; nrd = 0;
    for (int c = 0; c < 16; c++) begin
      if (rd_en) nrd++;
      if (m_valid && m_ready) begin
        check("t1_data", m_data, 64'h10 + 64'(n));
        check("t1_cycle", c, 2 + n);
        n++;
      end
      step();
    end
    check("t1_beats", n, 8);
    check("t1_rd_pulses", nrd, 8);
    check("t1_words", words, 8);
    check("t1_rd_idle", rd_en, 0);

    // T2: stalled consumer fills the skid buffer, then releases
    for (int k = 0; k < 8; k++) fifo_write(64'h10 + 64'(k));
    m_ready = 1'b0; #1;
    nrd = 0;
    for (int c = 0; c < 10; c++) begin
      if (rd_en) nrd++;
      if (m_valid) check("t2_hold", m_data, 64'h10);
      step();
    end
    check("t2_rd_pulses", nrd, 3);
    check("t2_occ", dut.u_skid.occ_q, 3);
    check("t2_valid", m_valid, 1);
    m_ready = 1'b1; #1;
    n = 0;
    for (int c = 0; c < 30 && n < 8; c++) begin
      if (m_valid) begin
        check("t2_data", m_data, 64'h10 + 64'(n));
        n++;
      end
      step();
    end
    check("t2_beats", n, 8);
    check("t2_words", words, 16);

    // T3: random writes and random ready, 1000 words
    base_push = pushes; base_pop = pops;
    wr = 0; rx = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 20000 && rx < 1000; c++) begin
      if (wr < 1000 && $urandom_range(1) == 1) begin
        fifo_write({$urandom(), $urandom()});
        wr++;
      end
      m_ready = ($urandom_range(1) == 1);
      #1;
      if (prev_stall) check("t3_hold", m_valid && (m_data == prev_data), 1);
      check("t3_credit", (pops - base_pop - rx) <= 3, 1);
      if (m_valid && m_ready) begin
        check("t3_data", m_data, fifo_mem[(base_push + rx) % 4096]);
        rx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      step();
    end
    check("t3_received", rx, 1000);
    check("t3_words", words, 1016);

    // T4: flush with words buffered, in flight and still queued
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) fifo_write(64'h20 + 64'(k));
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0; #1;
    check("t4_valid_drop", m_valid, 0);
    check("t4_busy", busy, 1);
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) ndone++;
      if (m_valid) check("t4_no_valid", m_valid, 0);
      step();
    end
    check("t4_done_pulses", ndone, 1);
    check("t4_busy_end", busy, 0);
    check("t4_words", words, 1016);
    check("t4_drained", pushes - pops, 0);
    fifo_write(64'hAA); fifo_write(64'hBB);
    m_ready = 1'b1; #1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_valid) begin
        check("t4_post_data", m_data, (n == 0) ? 64'hAA : 64'hBB);
        n++;
      end
      step();
    end
    check("t4_post_beats", n, 2);
    check("t4_post_words", words, 1018);

    // Flush of an already-empty FIFO
    flush = 1'b1;
    step();
    flush = 1'b0; #1;
    check("fe_busy", busy, 1);
    check("fe_done_early", done, 0);
    step();
    check("fe_busy_end", busy, 0);
    check("fe_done", done, 1);
    step();
    check("fe_done_clear", done, 0);
    check("fe_words", words, 1018);

    // T5: reset with occ=2 and a word in flight
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) fifo_write(64'h30 + 64'(k));
    step(); step(); step();
    check("t5_pre_occ", dut.u_skid.occ_q, 2);
    check("t5_pre_inflight", dut.inflight_q, 1);
    rst = 1'b1; #1;
    check("t5_rd_in_rst", rd_en, 0);
    step();
    rst = 1'b0; #1;
    check("t5_valid", m_valid, 0);
    check("t5_data", m_data, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_words", words, 0);
    m_ready = 1'b1; #1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (m_valid) begin
        check("t5_data_after", m_data, 64'h33);
        n++;
      end
      step();
    end
    check("t5_beats", n, 1);
    check("t5_words_after", words, 1);

    // T6: 4-bit counter wrap on a second instance
    fifo_empty4 = 1'b0; m_ready4 = 1'b1; #1;
    hs = 0;
    for (int c = 0; c < 60 && hs < 17; c++) begin
      if (m_valid4) begin
        check("t6_data", m_data4, 64'h5A);
        step();
        hs++;
        check("t6_count", words4, 64'(hs % 16));
        if (hs == 15) check("t6_at15", words4, 15);
        if (hs == 16) check("t6_wrap0", words4, 0);
        if (hs == 17) check("t6_wrap1", words4, 1);
      end else begin
        step();
      end
    end
    m_ready4 = 1'b0; fifo_empty4 = 1'b1;
    check("t6_handshakes", hs, 17);
    step(); step();
    check("t6_rd_idle", rd_en4, 0);
    check("t6_busy", busy4, 0);
    check("t6_done", done4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
